buzzer_envelope: RTL and testbench

Downstream tone stage for the buzzer music player. It takes the note period from the sequencer (the cycle count per tone period) and a per-note start strobe, and drives the active-low buzzer pin. The pin's duty cycle decays over the life of each note (attack, decay, sustain, release), so notes sound plucked rather than flat. The fixed-duty PWM in the player is replaced by this block's buzzer output.

---
 rtl/buzzer_envelope.sv | 130 +++++++++++++
 tb/tb_buzzer_envelope.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_envelope.sv
// Note-envelope tone stage: drives the active-low buzzer pin with a duty that shrinks from period/2^SHIFT_MIN to period/2^SHIFT_MAX.
// The buzzer pin is registered and trails note_start by two cycles. There is no backpressure; note_start retriggers at any time.
module buzzer_envelope #(
  parameter int TICK_CYCLES   = 50000,
  parameter int PERIOD_W      = 20,
  parameter int SHIFT_MIN     = 3,
  parameter int SHIFT_MAX     = 7,
  parameter int ATTACK_TICKS  = 20,
  parameter int DECAY_TICKS   = 40,
  parameter int RELEASE_TICKS = 30
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                note_start,
  input  logic [PERIOD_W-1:0] note_period,
  input  logic                note_hold,
  output logic                busy,
  output logic                buzzer
);

  localparam int PRESC_W = $clog2(TICK_CYCLES + 1);
  localparam int ENV_MAX = (ATTACK_TICKS > DECAY_TICKS)
                           ? ((ATTACK_TICKS > RELEASE_TICKS) ? ATTACK_TICKS : RELEASE_TICKS)
                           : ((DECAY_TICKS > RELEASE_TICKS) ? DECAY_TICKS : RELEASE_TICKS);
  localparam int ENV_W   = $clog2(ENV_MAX + 1);
  localparam int SHIFT_W = $clog2(SHIFT_MAX + 2);

  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

  state_t              state_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] phase_q;
  logic [PERIOD_W-1:0] phase_d;
  logic [PRESC_W-1:0]  presc_q;
  logic [PRESC_W-1:0]  presc_d;
  logic [ENV_W-1:0]    env_q;
  logic [SHIFT_W-1:0]  shift_q;
  logic                buzzer_q;
  logic                tick;
  logic [PERIOD_W-1:0] duty;

  assign tick    = (state_q != IDLE) && (presc_q == PRESC_W'(TICK_CYCLES - 1));
  assign presc_d = tick ? '0 : presc_q + PRESC_W'(1);
  // A zero period never wraps, so the period-1 compare cannot underflow into a live value.
  assign phase_d = ((period_q == '0) || (phase_q == period_q - PERIOD_W'(1)))
                   ? '0 : phase_q + PERIOD_W'(1);
  assign duty    = period_q >> shift_q;
  assign busy    = (state_q != IDLE);
  assign buzzer  = buzzer_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      period_q <= '0;
      phase_q  <= '0;
      presc_q  <= '0;
      env_q    <= '0;
      shift_q  <= SHIFT_W'(SHIFT_MIN);
      buzzer_q <= 1'b1;
    end else begin
      buzzer_q <= !((state_q != IDLE) && (duty != '0) && (phase_q < duty));

      if (note_start) begin
        state_q  <= ATTACK;
        period_q <= note_period;
        phase_q  <= '0;
        presc_q  <= '0;
        env_q    <= '0;
        shift_q  <= SHIFT_W'(SHIFT_MIN);
      end else begin
        if (state_q != IDLE) begin
          phase_q <= phase_d;
          presc_q <= presc_d;
        end

        case (state_q)
          ATTACK, DECAY, SUSTAIN: begin
            if (!note_hold) begin
              state_q <= RELEASE;
              shift_q <= SHIFT_W'(SHIFT_MAX);
              env_q   <= '0;
            end else if (tick && (state_q == ATTACK)) begin
              if (env_q == ENV_W'(ATTACK_TICKS - 1)) begin
                env_q <= '0;
                if (SHIFT_MIN + 1 >= SHIFT_MAX) begin
                  state_q <= SUSTAIN;
                  shift_q <= SHIFT_W'(SHIFT_MAX);
                end else begin
                  state_q <= DECAY;
                  shift_q <= SHIFT_W'(SHIFT_MIN + 1);
                end
              end else begin
                env_q <= env_q + ENV_W'(1);
              end
            end else if (tick && (state_q == DECAY)) begin
              if (env_q == ENV_W'(DECAY_TICKS - 1)) begin
                env_q   <= '0;
                shift_q <= shift_q + SHIFT_W'(1);
                if (shift_q == SHIFT_W'(SHIFT_MAX - 1)) begin
                  state_q <= SUSTAIN;
                end
              end else begin
                env_q <= env_q + ENV_W'(1);
              end
            end
          end

          RELEASE: begin
            if (tick) begin
              if (env_q == ENV_W'(RELEASE_TICKS - 1)) begin
                state_q <= IDLE;
                env_q   <= '0;
                phase_q <= '0;
                presc_q <= '0;
              end else begin
                env_q <= env_q + ENV_W'(1);
              end
            end
          end

          default: begin
            phase_q <= '0;
            presc_q <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buzzer_envelope.sv
// Directed plus randomized bench for buzzer_envelope; the reference derives the envelope from elapsed time since note start.
module tb_buzzer_envelope;

  localparam int TC   = 256;
  localparam int PW   = 20;
  localparam int SMIN = 3;
  localparam int SMAX = 7;
  localparam int AT   = 2;
  localparam int DT   = 1;
  localparam int RT   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          note_start = 1'b0;
  logic          note_hold = 1'b0;
  logic [PW-1:0] note_period = '0;
  logic          busy;
  logic          buzzer;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  buzzer_envelope #(
    .TICK_CYCLES(TC), .PERIOD_W(PW), .SHIFT_MIN(SMIN), .SHIFT_MAX(SMAX),
    .ATTACK_TICKS(AT), .DECAY_TICKS(DT), .RELEASE_TICKS(RT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .note_start(note_start), .note_period(note_period),
    .note_hold(note_hold), .busy(busy), .buzzer(buzzer)
  );

  // Reference: a note is described by its period, cycles elapsed since it began (k),
  // and the cycle at which release began (rel, -1 while still held).
  bit   m_on = 1'b0;
  int   m_k = 0;
  int   m_rel = -1;
  int   m_p = 0;
  logic exp_buz = 1'b1;
  logic exp_busy = 1'b0;

  function automatic int shift_at(int k, int rel);
    int t;
    int s;
    if (rel >= 0 && k >= rel) return SMAX;
    t = k / TC;
    if (t < AT) return SMIN;
    s = SMIN + 1 + (t - AT) / DT;
    return (s > SMAX) ? SMAX : s;
  endfunction

  // Cycle on which the last release tick lands (ticks fall on cycles k = n*TC-1).
  function automatic int rel_end(int rel);
    return ((rel + TC) / TC) * TC - 1 + (RT - 1) * TC;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_on     = 1'b0;
      exp_buz  = 1'b1;
      exp_busy = 1'b0;
    end else begin
      int duty;
      int ph;
      duty    = m_p >> shift_at(m_k, m_rel);
      ph      = (m_p == 0) ? 0 : (m_k % m_p);
      exp_buz = !(m_on && duty != 0 && ph < duty);
      if (note_start) begin
        m_on  = 1'b1;
        m_k   = 0;
        m_rel = -1;
        m_p   = int'(note_period);
      end else if (m_on) begin
        if (m_rel < 0 && !note_hold) m_rel = m_k + 1;
        if (m_rel >= 0 && m_k == rel_end(m_rel)) m_on = 1'b0;
        m_k++;
      end
      exp_busy = m_on;
    end
  end

  task automatic chk(input string tag, input int got, input int want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic run_cnt(input int n, input string tag, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (buzzer === 1'b0) lows++;
      n_assert++;
      assert (buzzer === exp_buz) else begin
        n_fail++;
        $error("FAIL %s buzzer @%0d: got %b want %b", tag, i, buzzer, exp_buz);
      end
      n_assert++;
      assert (busy === exp_busy) else begin
        n_fail++;
        $error("FAIL %s busy @%0d: got %b want %b", tag, i, busy, exp_busy);
      end
    end
  endtask

  task automatic run(input int n, input string tag);
    int dummy;
    run_cnt(n, tag, dummy);
  endtask

  task automatic start(input int p);
    note_start  = 1'b1;
    note_period = PW'(p);
    run(1, "strobe");
    note_start  = 1'b0;
    note_period = PW'($urandom);
  endtask

  initial begin
    int lows;
    int waited;

    // 1. reset and idle
    run(10, "reset");
    chk("reset_buzzer", int'(buzzer), 1);
    chk("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    run_cnt(100, "idle", lows);
    chk("idle_lows", lows, 0);

    // 2. plucked note, period 256
    note_hold = 1'b1;
    start(256);
    chk("busy_rise", int'(busy), 1);
    chk("buzzer_still_high", int'(buzzer), 1);
    run_cnt(1, "first_low", lows);
    chk("first_low", lows, 1);
    run_cnt(511, "attack_rest", lows);
    chk("attack_lows", lows + 1, 64);
    run_cnt(256, "decay4", lows);
    chk("decay_shift4", lows, 16);
    run_cnt(256, "decay5", lows);
    chk("decay_shift5", lows, 8);
    run_cnt(256, "decay6", lows);
    chk("decay_shift6", lows, 4);
    run_cnt(512, "sustain", lows);
    chk("sustain_lows", lows, 4);

    // 3. rest note
    start(0);
    run_cnt(2000, "rest_hold", lows);
    chk("rest_lows", lows, 0);
    note_hold = 1'b0;
    run_cnt(800, "rest_release", lows);
    chk("rest_release_lows", lows, 0);
    chk("rest_idle_busy", int'(busy), 0);

    // 4. release aligned to a tick boundary: k=1535 is the last held cycle
    note_hold = 1'b1;
    start(256);
    run(1535, "sus_build");
    note_hold = 1'b0;
    run(1, "rel_edge");
    run_cnt(768, "release", lows);
    chk("release_lows", lows, 6);
    chk("release_idle_busy", int'(busy), 0);
    chk("release_idle_buzzer", int'(buzzer), 1);

    // 5. retrigger mid-decay (shift 5 at k=800)
    note_hold = 1'b1;
    start(256);
    run(800, "pre_retrig");
    start(512);
    run_cnt(512, "retrig", lows);
    chk("retrig_lows", lows, 64);
    run(300, "retrig_tail");
    note_start  = 1'b1;
    note_hold   = 1'b0;
    note_period = PW'(512);
    run(1, "start_vs_fall");
    note_start  = 1'b0;
    note_hold   = 1'b1;
    run_cnt(512, "start_wins", lows);
    chk("start_wins_lows", lows, 64);
    chk("start_wins_busy", int'(busy), 1);

    // 6. async reset while the pin is sounding in sustain
    run(1800, "to_sustain");
    waited = 0;
    while (buzzer !== 1'b0 && waited < 600) begin
      run(1, "seek_low");
      waited++;
    end
    chk("seek_low_found", int'(buzzer === 1'b0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_buzzer", int'(buzzer), 1);
    chk("async_rst_busy", int'(busy), 0);
    run(5, "in_reset");
    rst_n = 1'b1;
    run_cnt(300, "post_reset", lows);
    chk("post_reset_lows", lows, 0);
    chk("post_reset_busy", int'(busy), 0);

    // randomized notes: periods, hold lengths, retriggers and gaps
    for (int n = 0; n < 10; n++) begin
      int p;
      p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(20, 700));
      note_hold = ($urandom_range(0, 7) != 0);
      start(p);
      note_hold = 1'b1;
      run(int'($urandom_range(0, 2500)), "rand_hold");
      note_hold = 1'b0;
      run(int'($urandom_range(0, 1200)), "rand_tail");
    end
    run(900, "final_drain");
    chk("final_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
